// File: rtl/cmd_uart_rx.sv
// cmd_uart_rx: 8N1 UART receiver that pairs framed bytes into 12-bit commands
// and strobes them onto the command bus.
module cmd_uart_rx #(
   parameter int CLK_HZ       = 50_000_000,
   parameter int BAUD         = 115_200,
   parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx,
   output logic        new_cmd,
   output logic [11:0] cmd_buf,
   output logic        frame_err,
   output logic        sync_err
);
   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} bit_state_e;
   typedef enum logic {A_WAIT_HI, A_WAIT_LO} asm_state_e;

   logic          rx_meta_q, rx_sync_q, rx_prev_q;
   bit_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    sh_q, sh_d;
   logic          tick, byte_ok, stop_bad;
   logic          vld_q;
   asm_state_e    asm_q, asm_d;
   logic [5:0]    hi_q, hi_d;
   logic [11:0]   cmd_q, cmd_d;
   logic          new_q, new_d, ferr_q, serr_q, serr_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         sh_q      <= '0;
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         sh_q      <= sh_d;
      end
   end

   // START times a half bit so later samples land mid-cell
   assign tick = cnt_q == ((state_q == S_START) ? HALF_M1 : FULL_M1);

   always_comb begin
      state_d = state_q;
      cnt_d   = tick ? '0 : cnt_q + 1'b1;
      bit_d   = bit_q;
      sh_d    = sh_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            if (rx_prev_q && !rx_sync_q) state_d = S_START;
         end
         S_START: if (tick) state_d = rx_sync_q ? S_IDLE : S_DATA;
         S_DATA: if (tick) begin
            sh_d  = {rx_sync_q, sh_q[7:1]};
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = S_STOP;
         end
         S_STOP: if (tick) state_d = rx_sync_q ? S_IDLE : S_BREAK;
         S_BREAK: begin
            cnt_d = '0;
            if (rx_sync_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      byte_ok  = (state_q == S_STOP) && tick && rx_sync_q;
      stop_bad = (state_q == S_STOP) && tick && !rx_sync_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q  <= 1'b0;
         asm_q  <= A_WAIT_HI;
         hi_q   <= '0;
         cmd_q  <= '0;
         new_q  <= 1'b0;
         ferr_q <= 1'b0;
         serr_q <= 1'b0;
      end else begin
         vld_q  <= byte_ok;
         asm_q  <= asm_d;
         hi_q   <= hi_d;
         cmd_q  <= cmd_d;
         new_q  <= new_d;
         ferr_q <= stop_bad;
         serr_q <= serr_d;
      end
   end

   // sh_q stays stable until the next frame's data bits, so it is the byte under test
   always_comb begin
      asm_d  = asm_q;
      hi_d   = hi_q;
      cmd_d  = cmd_q;
      new_d  = 1'b0;
      serr_d = 1'b0;
      if (stop_bad) asm_d = A_WAIT_HI;
      else if (vld_q) begin
         if (asm_q == A_WAIT_HI) begin
            serr_d = !(sh_q[7] && !sh_q[6]);
            if (sh_q[7] && !sh_q[6]) begin
               hi_d  = sh_q[5:0];
               asm_d = A_WAIT_LO;
            end
         end else if (sh_q[6]) begin
            serr_d = 1'b1;
            asm_d  = A_WAIT_HI;
         end else if (sh_q[7]) begin
            serr_d = 1'b1;
            hi_d   = sh_q[5:0];
         end else begin
            cmd_d = {hi_q, sh_q[5:0]};
            new_d = 1'b1;
            asm_d = A_WAIT_HI;
         end
      end
   end

   assign new_cmd   = new_q;
   assign cmd_buf   = cmd_q;
   assign frame_err = ferr_q;
   assign sync_err  = serr_q;
endmodule

// File: tb/tb_cmd_uart_rx.sv
// tb_cmd_uart_rx: directed bench for cmd_uart_rx at 10 clocks per bit.
module tb_cmd_uart_rx;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx = 1'b1;
   logic        new_cmd, frame_err, sync_err;
   logic [11:0] cmd_buf;
   int          checks = 0, failures = 0;
   int          n_new = 0, n_ferr = 0, n_serr = 0, n_bad = 0;
   logic [11:0] prev_cmd = '0;
   logic        rst_seen = 1'b0;

   cmd_uart_rx #(.CLK_HZ(1_000_000), .BAUD(100_000)) dut (
      .clk(clk), .rst_n(rst_n), .rx(rx), .new_cmd(new_cmd),
      .cmd_buf(cmd_buf), .frame_err(frame_err), .sync_err(sync_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rst_seen <= rst_n;

   // Pulse counters plus invariants: cmd_buf only moves with new_cmd, errors never coincide
   always @(negedge clk) begin
      n_new  += int'(new_cmd === 1'b1);
      n_ferr += int'(frame_err === 1'b1);
      n_serr += int'(sync_err === 1'b1);
      if (rst_seen && cmd_buf !== prev_cmd && new_cmd !== 1'b1) n_bad++;
      if (frame_err === 1'b1 && sync_err === 1'b1) n_bad++;
      prev_cmd = cmd_buf;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
      rx = 1'b0;
      wait_clk(10);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         wait_clk(10);
      end
      rx = stop;
      wait_clk(stop ? 10 : 40);
      rx = 1'b1;
      wait_clk(2);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      wait_clk(3);
      checks++; if (new_cmd !== 1'b0) begin failures++; $display("FAIL reset_new got=%b exp=0", new_cmd); end
      checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
      checks++; if (sync_err !== 1'b0) begin failures++; $display("FAIL reset_serr got=%b exp=0", sync_err); end
      checks++; if (cmd_buf !== 12'h000) begin failures++; $display("FAIL reset_cmd got=%h exp=000", cmd_buf); end
      rst_n = 1'b1;
      wait_clk(5);
   endtask

   task automatic test_basic();
      int n0 = n_new, f0 = n_ferr, s0 = n_serr;
      send_byte(8'h99);
      send_byte(8'h13);
      wait_clk(20);
      checks++; if (n_new - n0 != 1) begin failures++; $display("FAIL basic_new got=%0d exp=1", n_new - n0); end
      checks++; if (cmd_buf !== 12'h653) begin failures++; $display("FAIL basic_cmd got=%h exp=653", cmd_buf); end
      checks++; if (n_ferr - f0 != 0) begin failures++; $display("FAIL basic_ferr got=%0d exp=0", n_ferr - f0); end
      checks++; if (n_serr - s0 != 0) begin failures++; $display("FAIL basic_serr got=%0d exp=0", n_serr - s0); end
   endtask

   task automatic test_lone_low();
      int n0 = n_new, s0 = n_serr;
      send_byte(8'h13);
      wait_clk(20);
      checks++; if (n_serr - s0 != 1) begin failures++; $display("FAIL lone_low_serr got=%0d exp=1", n_serr - s0); end
      checks++; if (n_new - n0 != 0) begin failures++; $display("FAIL lone_low_new got=%0d exp=0", n_new - n0); end
      send_byte(8'h99);
      send_byte(8'h13);
      wait_clk(20);
      checks++; if (n_new - n0 != 1) begin failures++; $display("FAIL lone_low_pair_new got=%0d exp=1", n_new - n0); end
      checks++; if (cmd_buf !== 12'h653) begin failures++; $display("FAIL lone_low_cmd got=%h exp=653", cmd_buf); end
   endtask

   task automatic test_resync();
      int n0 = n_new, s0 = n_serr;
      send_byte(8'h99);
      send_byte(8'hBF);
      send_byte(8'h00);
      wait_clk(20);
      checks++; if (n_serr - s0 != 1) begin failures++; $display("FAIL resync_serr got=%0d exp=1", n_serr - s0); end
      checks++; if (n_new - n0 != 1) begin failures++; $display("FAIL resync_new got=%0d exp=1", n_new - n0); end
      checks++; if (cmd_buf !== 12'hFC0) begin failures++; $display("FAIL resync_cmd got=%h exp=FC0", cmd_buf); end
   endtask

   task automatic test_frame();
      int n0 = n_new, f0 = n_ferr, s0 = n_serr;
      send_byte(8'h99);
      send_byte(8'h13, 1'b0);
      wait_clk(20);
      checks++; if (n_ferr - f0 != 1) begin failures++; $display("FAIL frame_ferr got=%0d exp=1", n_ferr - f0); end
      checks++; if (n_new - n0 != 0) begin failures++; $display("FAIL frame_new got=%0d exp=0", n_new - n0); end
      checks++; if (cmd_buf !== 12'hFC0) begin failures++; $display("FAIL frame_cmd_held got=%h exp=FC0", cmd_buf); end
      send_byte(8'h99);
      send_byte(8'h13);
      wait_clk(20);
      checks++; if (n_serr - s0 != 0) begin failures++; $display("FAIL frame_serr got=%0d exp=0", n_serr - s0); end
      checks++; if (n_new - n0 != 1) begin failures++; $display("FAIL frame_after_new got=%0d exp=1", n_new - n0); end
      checks++; if (cmd_buf !== 12'h653) begin failures++; $display("FAIL frame_after_cmd got=%h exp=653", cmd_buf); end
   endtask

   task automatic test_glitch();
      int n0 = n_new, f0 = n_ferr, s0 = n_serr;
      rx = 1'b0;
      wait_clk(3);
      rx = 1'b1;
      wait_clk(30);
      checks++; if (n_new - n0 + n_ferr - f0 + n_serr - s0 != 0) begin failures++; $display("FAIL glitch_pulses got=%0d exp=0", n_new - n0 + n_ferr - f0 + n_serr - s0); end
      send_byte(8'h85);
      send_byte(8'h2A);
      wait_clk(20);
      checks++; if (n_new - n0 != 1) begin failures++; $display("FAIL glitch_after_new got=%0d exp=1", n_new - n0); end
      checks++; if (cmd_buf !== 12'h16A) begin failures++; $display("FAIL glitch_after_cmd got=%h exp=16A", cmd_buf); end
      checks++; if (n_serr - s0 != 0) begin failures++; $display("FAIL glitch_serr got=%0d exp=0", n_serr - s0); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] lo = 8'h13;
      int n0, s0;
      send_byte(8'h99);
      rx = 1'b0;
      wait_clk(10);
      for (int i = 0; i < 3; i++) begin
         rx = lo[i];
         wait_clk(10);
      end
      rx = lo[3];
      wait_clk(4);
      rst_n = 1'b0;
      wait_clk(1);
      checks++; if (cmd_buf !== 12'h000) begin failures++; $display("FAIL midrst_cmd got=%h exp=000", cmd_buf); end
      checks++; if ({new_cmd, frame_err, sync_err} !== 3'b000) begin failures++; $display("FAIL midrst_flags got=%b exp=000", {new_cmd, frame_err, sync_err}); end
      rst_n = 1'b1;
      rx = 1'b1;
      n0 = n_new;
      s0 = n_serr;
      wait_clk(40);
      checks++; if (n_new - n0 != 0) begin failures++; $display("FAIL midrst_no_new got=%0d exp=0", n_new - n0); end
      send_byte(8'h99);
      send_byte(8'h13);
      wait_clk(20);
      checks++; if (n_new - n0 != 1) begin failures++; $display("FAIL midrst_after_new got=%0d exp=1", n_new - n0); end
      checks++; if (cmd_buf !== 12'h653) begin failures++; $display("FAIL midrst_after_cmd got=%h exp=653", cmd_buf); end
      checks++; if (n_serr - s0 != 0) begin failures++; $display("FAIL midrst_serr got=%0d exp=0", n_serr - s0); end
   endtask

   task automatic test_invariants();
      checks++; if (n_bad != 0) begin failures++; $display("FAIL invariants got=%0d exp=0", n_bad); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_lone_low();
      test_resync();
      test_frame();
      test_glitch();
      test_reset_mid();
      test_invariants();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/cmd_uart_rx.md
Name: cmd_uart_rx

Overview:
- Serial front end for the command bus: receives 8N1 UART bytes on a single rx pin and assembles pairs of bytes into 12-bit commands {address[4:0], op[2:0], d[3:0]}.
- Presents each command on cmd_buf with a one-cycle new_cmd strobe.
- Sits directly upstream of the LED manager and any other address-decoded device on the same cmd_buf/new_cmd bus.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- BAUD, 115_200, line rate.
- CLKS_PER_BIT, CLK_HZ/BAUD (integer division), clocks per bit cell; must be >= 4.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- rx  input  1  asynchronous UART line, idle high.
- new_cmd  output  1  one-cycle pulse: cmd_buf holds a newly completed command.
- cmd_buf  output  12  last completed command, held stable between strobes.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- sync_err  output  1  one-cycle pulse: byte violated pair framing.

Behaviour:
- Reset (rst_n=0 at a clk edge): new_cmd=0, frame_err=0, sync_err=0, cmd_buf=12'h000; bit FSM to IDLE; assembler to WAIT_HI; counters cleared; synchronizer flops set to 1. Reset mid-frame abandons the partial byte/command with no pulse.
- rx passes through a 2-flop synchronizer. All references to rx below mean the synchronized value.
- Bit FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: a 1->0 transition on rx moves to START and clears the bit counter.
- START: at CLKS_PER_BIT/2 clocks, sample rx.
  - rx=1: false start; return to IDLE, no pulse.
  - rx=0: go to DATA.
- DATA: sample every CLKS_PER_BIT clocks, 8 bits, LSB first.
- STOP: sample after CLKS_PER_BIT clocks.
  - rx=1: byte valid, hand it to the assembler, go to IDLE.
  - rx=0: pulse frame_err, discard the byte, force assembler to WAIT_HI, go to BREAK.
- BREAK: wait for rx=1, then go to IDLE.
- Byte framing:
  - High byte = {1, 0, cmd[11:6]}.
  - Low byte = {0, 0, cmd[5:0]}.
  - Bit6 is reserved and must be 0.
- Assembler states: WAIT_HI, WAIT_LO.
  - WAIT_HI, valid high byte: latch the 6 bits, go to WAIT_LO.
  - WAIT_HI, bit7=0 or bit6=1: pulse sync_err, drop the byte, stay in WAIT_HI.
  - WAIT_LO, valid low byte: update cmd_buf, pulse new_cmd, go to WAIT_HI.
  - WAIT_LO, bit7=1 with bit6=0: pulse sync_err, treat the byte as a new high byte (resync), stay in WAIT_LO.
  - WAIT_LO, bit6=1: pulse sync_err, go to WAIT_HI.
- Latency: cmd_buf updates and new_cmd rises on the clk edge immediately after the edge that samples the low byte's stop bit. new_cmd is high for exactly one cycle.
- cmd_buf is never changed except together with new_cmd. No internal queue: each command is delivered once, and downstream must accept on the strobe.
- frame_err and sync_err never assert in the same cycle; frame_err preempts assembler checks.
- No timeout: a lone high byte waits indefinitely in WAIT_LO until the next byte arrives.

Test Plan:
- Sim config CLK_HZ=1_000_000, BAUD=100_000 (CLKS_PER_BIT=10). Send 0x99 then 0x13 -> exactly one new_cmd pulse, cmd_buf=12'h653 (addr 0x0C, op 101, d 3), about 10 clk after the second stop-bit midpoint edge minus the 9-clk slack; no error pulses.
- Send 0x13 alone, then 0x99, 0x13 -> sync_err pulse on the first byte; then new_cmd with cmd_buf=12'h653.
- Send 0x99, 0xBF, 0x00 -> sync_err on 0xBF (resync, high bits 6'h3F); new_cmd with cmd_buf=12'hFC0.
- Send 0x99, then a low byte whose stop bit is driven 0, hold rx low 30 clk, release, then send 0x99, 0x13 -> frame_err pulse, no new_cmd for the broken pair; then cmd_buf=12'h653.
- rx low glitch of 3 clk in IDLE -> false start, no pulses, state IDLE. Separately, assert rst_n=0 for 1 clk mid-DATA of the low byte -> all outputs 0, cmd_buf=12'h000; the next full pair decodes correctly.
